// File: rtl/sram_mport_pkg.sv
// Shared constants for the multi-port asynchronous SRAM controller.
// Holds the FSM state encoding and the default parameter values.
package sram_mport_pkg;

    localparam int DEF_NUM_PORTS   = 2;
    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_CYCLES = 1;

    localparam int CNT_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last
// granted port, cyclically. The pointer only advances when the grant is taken.
module sram_rr_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 update,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 any_req
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] last_q;
    int               win;

    // Scan distances 1..NUM_PORTS from the last winner; the first hit wins.
    always_comb begin
        grant   = '0;
        win     = 0;
        any_req = 1'b0;
        for (int d = 1; d <= NUM_PORTS; d++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!any_req && req[j] && (j == (int'(last_q) + d) % NUM_PORTS)) begin
                    any_req  = 1'b1;
                    win      = j;
                    grant[j] = 1'b1;
                end
            end
        end
    end

    // Reset points at the last port so port 0 is served first.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            last_q <= PTR_W'(NUM_PORTS - 1);
        end else if (update && any_req) begin
            last_q <= PTR_W'(win);
        end
    end

endmodule

// File: rtl/sram_mport_ctrl.sv
// Multi-port controller for an asynchronous 16-bit SRAM: arbitrates bridge
// style requesters round-robin and runs IDLE/SETUP/ACCESS/DONE per access.
module sram_mport_ctrl
    import sram_mport_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [NUM_PORTS*(ADDR_W+1)-1:0] port_address,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] port_byte_enable,
    input  logic [NUM_PORTS-1:0]          port_read,
    input  logic [NUM_PORTS-1:0]          port_write,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_write_data,
    output logic [NUM_PORTS-1:0]          port_acknowledge,
    output logic [DATA_W-1:0]             port_read_data,
    inout  wire  [DATA_W-1:0]             sram_DQ,
    output logic [ADDR_W-1:0]             sram_ADDR,
    output logic                          sram_LB_N,
    output logic                          sram_UB_N,
    output logic                          sram_CE_N,
    output logic                          sram_OE_N,
    output logic                          sram_WE_N
);

    localparam int BE_W = DATA_W / 8;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t [NUM_PORTS-1:0] port_req;
    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] unused_addr_lsb;
    logic [NUM_PORTS-1:0] grant;
    logic                 any_req;
    req_t                 sel;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 wr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [NUM_PORTS-1:0] gnt_q;
    logic                 dq_oe;

    // Write wins when a port raises read and write together.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign port_req[p] = {port_write[p],
                              port_address[p*(ADDR_W+1)+1 +: ADDR_W],
                              port_byte_enable[p*BE_W +: BE_W],
                              port_write_data[p*DATA_W +: DATA_W]};
        assign req_vec[p]         = port_read[p] | port_write[p];
        assign unused_addr_lsb[p] = port_address[p*(ADDR_W+1)];
    end

    sram_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .req           (req_vec),
        .update        (state == ST_IDLE),
        .grant         (grant),
        .any_req       (any_req)
    );

    always_comb begin
        sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) sel = port_req[p];
        end
    end

    assign sram_DQ = dq_oe ? wdata_q : 'z;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            wr_q             <= 1'b0;
            wdata_q          <= '0;
            gnt_q            <= '0;
            dq_oe            <= 1'b0;
            sram_ADDR        <= '0;
            sram_CE_N        <= 1'b1;
            sram_OE_N        <= 1'b1;
            sram_WE_N        <= 1'b1;
            sram_LB_N        <= 1'b1;
            sram_UB_N        <= 1'b1;
            port_acknowledge <= '0;
            port_read_data   <= '0;
        end else begin
            port_acknowledge <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        wr_q      <= sel.wr;
                        wdata_q   <= sel.data;
                        gnt_q     <= grant;
                        sram_ADDR <= sel.addr;
                        sram_CE_N <= 1'b0;
                        sram_LB_N <= ~sel.be[0];
                        sram_UB_N <= ~sel.be[BE_W-1];
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt <= CNT_W'(WAIT_CYCLES);
                    if (wr_q) begin
                        sram_WE_N <= 1'b0;
                        dq_oe     <= 1'b1;
                    end else begin
                        sram_OE_N <= 1'b0;
                    end
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Read data is sampled on the same edge that releases OE_N.
                    if (cnt == '0) begin
                        if (!wr_q) port_read_data <= sram_DQ;
                        sram_CE_N        <= 1'b1;
                        sram_OE_N        <= 1'b1;
                        sram_WE_N        <= 1'b1;
                        sram_LB_N        <= 1'b1;
                        sram_UB_N        <= 1'b1;
                        dq_oe            <= 1'b0;
                        port_acknowledge <= gnt_q;
                        state            <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mport_ctrl.sv
// Self-checking bench for sram_mport_ctrl: behavioural SRAM, reference memory
// and a scoreboard queue popped by a monitor on each acknowledge.
module tb_sram_mport_ctrl;

    localparam int NP = 3;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int W  = 1;
    localparam int PERIOD = W + 4;

    logic                  clk_clk = 1'b0;
    logic                  reset_reset_n = 1'b0;
    logic [NP*(AW+1)-1:0]  port_address;
    logic [NP*2-1:0]       port_byte_enable;
    logic [NP-1:0]         port_read;
    logic [NP-1:0]         port_write;
    logic [NP*DW-1:0]      port_write_data;
    logic [NP-1:0]         port_acknowledge;
    logic [DW-1:0]         port_read_data;
    wire  [DW-1:0]         sram_DQ;
    logic [AW-1:0]         sram_ADDR;
    logic                  sram_LB_N, sram_UB_N, sram_CE_N, sram_OE_N, sram_WE_N;

    logic [AW:0]   p_addr [NP];
    logic [1:0]    p_be   [NP];
    logic [DW-1:0] p_wd   [NP];
    logic [NP-1:0] p_rd, p_wr;

    always #5 clk_clk = ~clk_clk;

    always_comb begin
        port_address     = '0;
        port_byte_enable = '0;
        port_write_data  = '0;
        for (int i = 0; i < NP; i++) begin
            port_address[i*(AW+1) +: AW+1] = p_addr[i];
            port_byte_enable[i*2 +: 2]     = p_be[i];
            port_write_data[i*DW +: DW]    = p_wd[i];
        end
        port_read  = p_rd;
        port_write = p_wr;
    end

    sram_mport_ctrl #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .port_address     (port_address),
        .port_byte_enable (port_byte_enable),
        .port_read        (port_read),
        .port_write       (port_write),
        .port_write_data  (port_write_data),
        .port_acknowledge (port_acknowledge),
        .port_read_data   (port_read_data),
        .sram_DQ          (sram_DQ),
        .sram_ADDR        (sram_ADDR),
        .sram_LB_N        (sram_LB_N),
        .sram_UB_N        (sram_UB_N),
        .sram_CE_N        (sram_CE_N),
        .sram_OE_N        (sram_OE_N),
        .sram_WE_N        (sram_WE_N)
    );

    // Behavioural asynchronous SRAM, 256 words visible.
    logic [DW-1:0] mem [0:255];
    wire sram_drive = !sram_CE_N && !sram_OE_N && sram_WE_N;
    assign sram_DQ = sram_drive ? mem[sram_ADDR[7:0]] : 'z;
    always @(posedge clk_clk) begin
        if (!sram_CE_N && !sram_WE_N) begin
            if (!sram_LB_N) mem[sram_ADDR[7:0]][7:0]  <= sram_DQ[7:0];
            if (!sram_UB_N) mem[sram_ADDR[7:0]][15:8] <= sram_DQ[15:8];
        end
    end

    typedef struct {
        int            port;
        bit            wr;
        logic [AW-1:0] waddr;
        logic [1:0]    be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [0:255];
    int            last_grant = NP - 1;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] be);
        merge = old;
        if (be[0]) merge[7:0]  = nw[7:0];
        if (be[1]) merge[15:8] = nw[15:8];
    endfunction

    function automatic int next_grant(input bit [NP-1:0] m, input int last);
        for (int i = 1; i <= NP; i++) begin
            if (m[(last + i) % NP]) return (last + i) % NP;
        end
        return -1;
    endfunction

    task automatic push_exp(input int p, input bit wr, input logic [AW:0] baddr,
                            input logic [1:0] be, input logic [DW-1:0] d);
        exp_t e;
        int   w;
        w       = int'(baddr[8:1]);
        e.port  = p;
        e.wr    = wr;
        e.waddr = baddr[AW:1];
        e.be    = be;
        e.wdata = d;
        e.rdata = '0;
        if (wr) ref_mem[w] = merge(ref_mem[w], d, be);
        else    e.rdata    = ref_mem[w];
        exp_q.push_back(e);
        last_grant = p;
    endtask

    // One transaction on one port; ack must land in the DONE cycle, which is
    // the (W+4)th cycle counting the request-sampling IDLE cycle as the first.
    task automatic do_txn(input int p, input bit rd, input bit wr, input logic [AW:0] baddr,
                          input logic [1:0] be, input logic [DW-1:0] d);
        int n;
        push_exp(p, wr, baddr, be, d);
        @(negedge clk_clk);
        p_addr[p] = baddr; p_be[p] = be; p_wd[p] = d; p_rd[p] = rd; p_wr[p] = wr;
        n = 0;
        do begin
            @(negedge clk_clk);
            n++;
        end while (!port_acknowledge[p] && n < 60);
        p_rd[p] = 1'b0; p_wr[p] = 1'b0;
        if (!port_acknowledge[p]) begin
            errors++;
            $display("FAIL ack_timeout: port %0d no ack after %0d cycles", p, n);
            finish_run();
        end
        chk("latency", n, W + 3);
        repeat ($urandom_range(0, 2)) @(negedge clk_clk);
    endtask

    // Several ports hold requests; grants follow the round-robin rule and each
    // port drops its request on the ack that completes its planned share.
    task automatic rr_burst(input bit [NP-1:0] mask, input int k);
        int          plan [NP];
        int          got  [NP];
        bit          opw  [NP];
        logic [AW:0] ad   [NP];
        logic [DW-1:0] dd [NP];
        int          p, n, prev, acks;
        for (int i = 0; i < NP; i++) begin
            plan[i] = 0; got[i] = 0;
            opw[i]  = 1'($urandom_range(0, 1));
            ad[i]   = (AW+1)'($urandom_range(0, 31) * 2);
            dd[i]   = DW'($urandom);
        end
        for (int i = 0; i < k; i++) begin
            p = next_grant(mask, last_grant);
            push_exp(p, opw[p], ad[p], 2'b11, dd[p]);
            plan[p]++;
        end
        @(negedge clk_clk);
        for (int i = 0; i < NP; i++) begin
            if (mask[i]) begin
                p_addr[i] = ad[i]; p_be[i] = 2'b11; p_wd[i] = dd[i];
                p_rd[i] = !opw[i]; p_wr[i] = opw[i];
            end
        end
        n = 0; prev = 0; acks = 0;
        while (acks < k && n < k * PERIOD + 40) begin
            @(negedge clk_clk);
            n++;
            if (|port_acknowledge) begin
                for (int i = 0; i < NP; i++) begin
                    if (port_acknowledge[i]) begin
                        got[i]++;
                        if (got[i] >= plan[i]) begin p_rd[i] = 1'b0; p_wr[i] = 1'b0; end
                    end
                end
                if (acks > 0) chk("rr_period", n - prev, PERIOD);
                prev = n;
                acks++;
            end
        end
        p_rd = '0; p_wr = '0;
        if (acks < k) begin
            errors++;
            $display("FAIL rr_timeout: got %0d acks, expected %0d", acks, k);
            finish_run();
        end
        repeat (2) @(negedge clk_clk);
    endtask

    // Monitor: per-access strobe/address/data checks, scoreboard pop on ack.
    int            we_cnt = 0, oe_cnt = 0;
    bit            sig_bad = 1'b0;
    logic [DW-1:0] last_rd = '0;
    exp_t          me;

    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            we_cnt = 0; oe_cnt = 0; sig_bad = 1'b0; last_rd = '0;
        end else begin
            if (!sram_OE_N && !sram_WE_N) chk("oe_we_overlap", {sram_OE_N, sram_WE_N}, 2'b11);
            if ($countones(port_acknowledge) > 1) chk("ack_onehot", $countones(port_acknowledge), 1);
            if (!sram_CE_N && (!sram_WE_N || !sram_OE_N)) begin
                if (!sram_WE_N) we_cnt++;
                if (!sram_OE_N) oe_cnt++;
                if (exp_q.size() > 0) begin
                    if (sram_ADDR !== exp_q[0].waddr) sig_bad = 1'b1;
                    if ({sram_UB_N, sram_LB_N} !== ~exp_q[0].be) sig_bad = 1'b1;
                    if (!sram_WE_N && sram_DQ !== exp_q[0].wdata) sig_bad = 1'b1;
                end
            end
            if (|port_acknowledge) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(port_acknowledge), 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("ack_port", 32'(port_acknowledge), 32'(1) << me.port);
                    chk("we_cycles", we_cnt, me.wr ? W + 1 : 0);
                    chk("oe_cycles", oe_cnt, me.wr ? 0 : W + 1);
                    chk("access_signals", sig_bad, 0);
                    if (!me.wr) last_rd = me.rdata;
                    chk("read_data", port_read_data, last_rd);
                    chk("done_strobes", {sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}, 5'h1f);
                end
                we_cnt = 0; oe_cnt = 0; sig_bad = 1'b0;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobes"}, {sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}, 5'h1f);
        chk({tag, "_addr"}, sram_ADDR, 0);
        chk({tag, "_ack"}, 32'(port_acknowledge), 0);
        chk({tag, "_rdata"}, port_read_data, 0);
    endtask

    initial begin
        int n;
        int op;
        p_rd = '0; p_wr = '0;
        for (int i = 0; i < NP; i++) begin p_addr[i] = '0; p_be[i] = '0; p_wd[i] = '0; end
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk_clk);
        chk_reset_outputs("reset");
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // Directed: write A55A at byte 0x10, read it back on port 1.
        do_txn(0, 1'b0, 1'b1, 21'h00010, 2'b11, 16'hA55A);
        do_txn(1, 1'b1, 1'b0, 21'h00010, 2'b11, 16'h0000);
        // Low-byte-only write over FFFF reads back FF34.
        do_txn(0, 1'b0, 1'b1, 21'h00012, 2'b11, 16'hFFFF);
        do_txn(2, 1'b0, 1'b1, 21'h00013, 2'b01, 16'h1234);
        do_txn(1, 1'b1, 1'b0, 21'h00012, 2'b00, 16'h0000);
        // Read+write with no byte lanes: a write cycle that changes nothing.
        do_txn(0, 1'b1, 1'b1, 21'h00010, 2'b00, 16'h0F0F);
        do_txn(2, 1'b1, 1'b0, 21'h00010, 2'b11, 16'h0000);

        for (int w = 0; w < 32; w++)
            do_txn(w % NP, 1'b0, 1'b1, (AW+1)'(w * 2), 2'b11, DW'($urandom));

        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 2);
            do_txn($urandom_range(0, NP - 1), op != 1, op != 0,
                   (AW+1)'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), DW'($urandom));
        end

        rr_burst(3'b011, 6);
        rr_burst(3'b111, 9);
        rr_burst(3'b101, 4);

        // Reset during the strobe of a write to a word that is never read back.
        @(negedge clk_clk);
        p_addr[1] = 21'h00050; p_be[1] = 2'b11; p_wd[1] = 16'hDEAD; p_wr[1] = 1'b1;
        n = 0;
        while (sram_WE_N && n < 20) begin @(negedge clk_clk); n++; end
        chk("abort_reached_access", sram_WE_N, 0);
        reset_reset_n = 1'b0;
        p_wr[1] = 1'b0;
        @(negedge clk_clk);
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        last_grant = NP - 1;
        @(negedge clk_clk);
        chk("abort_no_ack", 32'(port_acknowledge), 0);

        rr_burst(3'b011, 6);
        do_txn(1, 1'b1, 1'b0, 21'h00012, 2'b11, 16'h0000);

        repeat (5) @(negedge clk_clk);
        chk("queue_drained", exp_q.size(), 0);
        finish_run();
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

endmodule
